nibble_serial_add_ctrl: RTL

Sequencer that performs a WIDTH-bit addition by time-multiplexing a single 4-bit ripple-carry adder (module RCA) over WIDTH/4 nibble cycles, least-significant nibble first.
- Carries the inter-nibble carry in a register.
- Uses a start/busy/done handshake.
- Used wherever wide adds are needed but area must stay at one 4-bit adder.

---
 rtl/nsa_pkg.sv | 22 ++
 rtl/nibble_serial_add_ctrl_rca.sv | 27 ++
 rtl/nibble_serial_add_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/nsa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nsa_pkg
// Brief    : Shared types and helpers for the nibble-serial adder sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl_rca.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl_rca
// Brief    : 4-bit ripple-carry adder shared by every nibble cycle.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl_rca (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [4:0] w_c;

    assign w_c[0] = c_in;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign c_out = w_c[4];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl
// Brief    : WIDTH-bit add sequenced LSB nibble first over one 4-bit RCA.
//            Optional macro NSA_SUB_EN adds a 'sub' port for a - b.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef NSA_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int c_nibs  = nib_count(WIDTH);
    localparam int c_cnt_w = (c_nibs > 1) ? $clog2(c_nibs) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nibs - 1);

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_width_check
        $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end

    nsa_state_t         r_state;
    nsa_state_t         w_state_next;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_work;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_accept;
    logic               w_last;
    logic               w_sub;
    logic               w_init_carry;
    logic [3:0]         w_y;
    logic [3:0]         w_s;
    logic               w_rca_cout;
    logic [WIDTH-1:0]   w_work_next;

`ifdef NSA_SUB_EN
    logic r_sub;

    assign w_sub        = r_sub;
    assign w_init_carry = sub ? 1'b1 : c_in;
`else
    assign w_sub        = 1'b0;
    assign w_init_carry = c_in;
`endif

    assign w_accept    = (r_state == IDLE) && start;
    assign w_last      = (r_cnt == c_last);
    // Subtraction is a + ~b + 1, so only the B nibble is inverted here.
    assign w_y         = r_b_sh[3:0] ^ {4{w_sub}};
    assign w_work_next = {w_s, r_work[WIDTH-1:NIBBLE_W]};

    nibble_serial_add_ctrl_rca u_rca (
        .x     (r_a_sh[3:0]),
        .y     (w_y),
        .c_in  (r_carry),
        .s     (w_s),
        .c_out (w_rca_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) w_state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Results go to a working register so sum never shows partial nibbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_work  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
`ifdef NSA_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= w_init_carry;
            r_cnt   <= '0;
`ifdef NSA_SUB_EN
            r_sub   <= sub;
`endif
        end else if (r_state == RUN) begin
            r_a_sh  <= {{NIBBLE_W{1'b0}}, r_a_sh[WIDTH-1:NIBBLE_W]};
            r_b_sh  <= {{NIBBLE_W{1'b0}}, r_b_sh[WIDTH-1:NIBBLE_W]};
            r_carry <= w_rca_cout;
            r_cnt   <= r_cnt + c_cnt_w'(1);
            r_work  <= w_work_next;
            if (w_last) begin
                r_sum  <= w_work_next;
                r_cout <= w_rca_cout;
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_cout;

endmodule
`default_nettype wire
